upg_boot_ctrl: RTL and testbench
================================

// Module: upg_boot_ctrl
// PURPOSE
//  Boot/programming sequencer and memory-port arbiter between the CPU core and the UART loader.
//  Holds the CPU in reset while the UART streams a program image.
//  Steers loader words to the instruction ROM or data RAM; hands the data RAM port back to the CPU afterwards.
//  Sits between the top-level CPU, uart, programrom and dmemory32.
// PARAMETERS
//  ADDR_W    14  word-address width of imem/dmem ports
//  DATA_W    32  memory data width
//  RST_HOLD  16  cycles cpu_rst_o stays high after reset release or programming end (>=1)
// PORTS
//  clk          in   1       system clock (all logic on posedge)
//  rst          in   1       asynchronous active-high reset
//  start_pg     in   1       programming-request button, asynchronous level
//  upg_wen_i    in   1       loader word-write strobe, 1 cycle per word
//  upg_adr_i    in   ADDR_W+1  loader address; MSB 1=dmem, 0=imem; low ADDR_W bits = word address
//  upg_dat_i    in   DATA_W  loader write data
//  upg_done_i   in   1       loader reports image complete
//  cpu_wen_i    in   1       CPU data-RAM write enable
//  cpu_adr_i    in   ADDR_W  CPU data-RAM word address
//  cpu_dat_i    in   DATA_W  CPU data-RAM write data
//  upg_rst_o    out  1       1 = loader held in reset; 0 = programming session open
//  cpu_rst_o    out  1       CPU reset request
//  imem_wen_o / imem_adr_o / imem_dat_o  out  1/ADDR_W/DATA_W  instruction-ROM write port
//  dmem_wen_o / dmem_adr_o / dmem_dat_o  out  1/ADDR_W/DATA_W  data-RAM write port
//  busy_o       out  1       high in PROG
//  word_cnt_o   out  16      words accepted in last session, saturating at 16'hFFFF
//  err_o        out  1       sticky: cpu_wen_i seen during PROG
// BEHAVIOUR
//  Reset values: state=HOLD; hold_cnt=0; upg_rst_o=1; cpu_rst_o=1; busy_o=0; word_cnt_o=0; err_o=0.
//  Reset is asynchronous and may arrive in any state, including mid-session.
//  A mid-session reset aborts the session, leaves word_cnt_o=0, and forces HOLD.
//  start_pg passes through a 2-flop synchronizer; a rising edge of the synced signal is the start event.
//  The 2-cycle synchronizer delay is part of the start latency.
//  States:
//   HOLD: cpu_rst_o=1, upg_rst_o=1, all wen outputs 0.
//         hold_cnt increments each cycle; at hold_cnt==RST_HOLD-1, go to RUN and clear hold_cnt.
//   RUN:  cpu_rst_o=0, upg_rst_o=1.
//         dmem_* = cpu_* combinationally (0 latency); imem_wen_o=0.
//         On start event, go to PROG: clear word_cnt_o and err_o the same cycle.
//   PROG: cpu_rst_o=1, upg_rst_o=0, busy_o=1.
//         When upg_wen_i=1, the write routes to imem if upg_adr_i[ADDR_W]=0, else to dmem, with upg_adr_i[ADDR_W-1:0].
//         The other port's wen is 0. word_cnt_o increments, saturating.
//         cpu_wen_i is ignored for memory and sets err_o.
//         On upg_done_i=1, go to HOLD (hold_cnt=0).
//  Simultaneous upg_wen_i and upg_done_i in PROG: the write is performed and counted, then HOLD.
//  Start events in PROG or HOLD are ignored; there is no re-arm until RUN.
//  upg_wen_i outside PROG is ignored and not counted.
//  State-derived outputs (cpu_rst_o, upg_rst_o, busy_o) are registered.
//  Memory-port muxing is combinational on the registered state.
//  Address/data outputs are don't-care when the corresponding wen is 0; they are driven to 0 in HOLD.
// TESTING
//  1. Reset, then release -> cpu_rst_o=1 for exactly 16 cycles, then RUN; CPU write (adr 5, data 32'hA5A5) appears on the dmem port in the same cycle.
//  2. Start pulse in RUN -> PROG within 3 cycles; upg_rst_o=0.
//     Loader writes adr 15'h0003 -> imem_adr_o=3, imem_wen_o=1.
//     Loader writes adr 15'h4007 -> dmem_adr_o=7, dmem_wen_o=1.
//     word_cnt_o=2.
//  3. In PROG, assert upg_wen_i and upg_done_i in the same cycle -> write occurs, word_cnt_o=1, then HOLD.
//     After 16 cycles, RUN with cpu_rst_o=0.
//  4. In PROG, pulse cpu_wen_i -> dmem_wen_o stays 0, err_o=1 until the next start event clears it.
//  5. Assert rst mid-PROG after 3 words -> upg_rst_o=1, cpu_rst_o=1, word_cnt_o=0 immediately; RUN after the 16-cycle hold.
//  6. Force word_cnt_o to 16'hFFFF with further writes -> it stays at 16'hFFFF; a start pulse during HOLD is ignored.

Source files
------------

// File: rtl/upg_boot_ctrl.sv
// -----------------------------------------------------------------------------
// upg_boot_ctrl
//   Boot/programming sequencer and memory-port arbiter between the CPU core and
//   the UART loader. The CPU is held in reset while the loader streams a program
//   image; loader words are steered to the instruction ROM or the data RAM, and
//   the data-RAM port is handed back to the CPU once the image is complete.
//
// Ports
//   clk, rst        system clock (posedge), asynchronous active-high reset
//   start_pg        programming-request button (asynchronous level)
//   upg_wen_i       loader word-write strobe (1 cycle per word)
//   upg_adr_i       loader address, MSB selects dmem(1)/imem(0)
//   upg_dat_i       loader write data
//   upg_done_i      loader reports image complete
//   cpu_wen_i/adr/dat  CPU data-RAM write port
//   upg_rst_o       1 = loader held in reset, 0 = programming session open
//   cpu_rst_o       CPU reset request
//   imem_*_o        instruction-ROM write port
//   dmem_*_o        data-RAM write port
//   busy_o          high while programming
//   word_cnt_o      words accepted in the last session (saturating)
//   err_o           sticky: CPU write attempted during programming
// -----------------------------------------------------------------------------
module upg_boot_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int RST_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pg,
  input  logic              upg_wen_i,
  input  logic [ADDR_W:0]   upg_adr_i,
  input  logic [DATA_W-1:0] upg_dat_i,
  input  logic              upg_done_i,
  input  logic              cpu_wen_i,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  input  logic [DATA_W-1:0] cpu_dat_i,
  output logic              upg_rst_o,
  output logic              cpu_rst_o,
  output logic              imem_wen_o,
  output logic [ADDR_W-1:0] imem_adr_o,
  output logic [DATA_W-1:0] imem_dat_o,
  output logic              dmem_wen_o,
  output logic [ADDR_W-1:0] dmem_adr_o,
  output logic [DATA_W-1:0] dmem_dat_o,
  output logic              busy_o,
  output logic [15:0]       word_cnt_o,
  output logic              err_o
);

  localparam int HC_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_PROG = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]     word_cnt_q, word_cnt_d;
  logic            err_q, err_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            upg_rst_q, upg_rst_d;
  logic            busy_q, busy_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic            start_evt;

  // sync3_q is the previous synchronized level, used only for edge detection.
  assign start_evt = sync2_q & ~sync3_q;

  // Next-state and counters.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (start_evt) begin
          state_d    = S_PROG;
          word_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      S_PROG: begin
        if (upg_wen_i && (word_cnt_q != '1)) begin
          word_cnt_d = word_cnt_q + 16'd1;
        end
        if (cpu_wen_i) begin
          err_d = 1'b1;
        end
        // A write in the same cycle as done is still counted above.
        if (upg_done_i) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State-derived outputs are registered from the next state so they line up
  // with state_q without an extra cycle of lag.
  always_comb begin
    cpu_rst_d = (state_d != S_RUN);
    upg_rst_d = (state_d != S_PROG);
    busy_d    = (state_d == S_PROG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
      upg_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
      upg_rst_q  <= upg_rst_d;
      busy_q     <= busy_d;
      sync1_q    <= start_pg;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
    end
  end

  // Memory-port steering, combinational on the registered state.
  always_comb begin
    imem_wen_o = 1'b0;
    imem_adr_o = '0;
    imem_dat_o = '0;
    dmem_wen_o = 1'b0;
    dmem_adr_o = '0;
    dmem_dat_o = '0;
    unique case (state_q)
      S_RUN: begin
        dmem_wen_o = cpu_wen_i;
        dmem_adr_o = cpu_adr_i;
        dmem_dat_o = cpu_dat_i;
      end
      S_PROG: begin
        imem_adr_o = upg_adr_i[ADDR_W-1:0];
        imem_dat_o = upg_dat_i;
        dmem_adr_o = upg_adr_i[ADDR_W-1:0];
        dmem_dat_o = upg_dat_i;
        imem_wen_o = upg_wen_i & ~upg_adr_i[ADDR_W];
        dmem_wen_o = upg_wen_i &  upg_adr_i[ADDR_W];
      end
      default: begin
      end
    endcase
  end

  assign cpu_rst_o  = cpu_rst_q;
  assign upg_rst_o  = upg_rst_q;
  assign busy_o     = busy_q;
  assign word_cnt_o = word_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_upg_boot_ctrl.sv
module tb_upg_boot_ctrl;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_pg;
  logic              upg_wen_i;
  logic [ADDR_W:0]   upg_adr_i;
  logic [DATA_W-1:0] upg_dat_i;
  logic              upg_done_i;
  logic              cpu_wen_i;
  logic [ADDR_W-1:0] cpu_adr_i;
  logic [DATA_W-1:0] cpu_dat_i;
  logic              upg_rst_o;
  logic              cpu_rst_o;
  logic              imem_wen_o;
  logic [ADDR_W-1:0] imem_adr_o;
  logic [DATA_W-1:0] imem_dat_o;
  logic              dmem_wen_o;
  logic [ADDR_W-1:0] dmem_adr_o;
  logic [DATA_W-1:0] dmem_dat_o;
  logic              busy_o;
  logic [15:0]       word_cnt_o;
  logic              err_o;

  int total = 0;
  int bad   = 0;

  upg_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD(16)) dut (
    .clk(clk), .rst(rst), .start_pg(start_pg),
    .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
    .upg_done_i(upg_done_i),
    .cpu_wen_i(cpu_wen_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .upg_rst_o(upg_rst_o), .cpu_rst_o(cpu_rst_o),
    .imem_wen_o(imem_wen_o), .imem_adr_o(imem_adr_o), .imem_dat_o(imem_dat_o),
    .dmem_wen_o(dmem_wen_o), .dmem_adr_o(dmem_adr_o), .dmem_dat_o(dmem_dat_o),
    .busy_o(busy_o), .word_cnt_o(word_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Count posedges until cpu_rst_o falls (bounded), checking the hold length.
  task automatic test_hold_len(input string name);
    int n = 0;
    while (cpu_rst_o && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL %s hold cycles got=%0d exp=16", name, n);
    end
    total++;
    if (upg_rst_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s run outputs upg_rst=%b busy=%b exp 1/0", name, upg_rst_o, busy_o);
    end
  endtask

  // Raise start_pg from RUN and wait (bounded) for PROG.
  task automatic test_start(input string name);
    int n = 0;
    @(negedge clk);
    start_pg = 1'b1;
    while (!busy_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n < 1 || n > 3) begin
      bad++;
      $display("FAIL %s start latency got=%0d exp<=3", name, n);
    end
    total++;
    if (upg_rst_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL %s prog outputs upg_rst=%b cpu_rst=%b exp 0/1", name, upg_rst_o, cpu_rst_o);
    end
    @(negedge clk);
    start_pg = 1'b0;
  endtask

  task automatic loader_write(input logic [ADDR_W:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    upg_wen_i = 1'b1; upg_adr_i = a; upg_dat_i = d;
    @(negedge clk);
    upg_wen_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if (cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1 || busy_o !== 1'b0 ||
        word_cnt_o !== 16'h0 || err_o !== 1'b0 || imem_wen_o !== 1'b0 || dmem_wen_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals cpu_rst=%b upg_rst=%b busy=%b cnt=%h err=%b iw=%b dw=%b exp 1 1 0 0000 0 0 0",
               cpu_rst_o, upg_rst_o, busy_o, word_cnt_o, err_o, imem_wen_o, dmem_wen_o);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_hold_len("reset_release");
    @(negedge clk);
    cpu_wen_i = 1'b1; cpu_adr_i = 14'd5; cpu_dat_i = 32'h0000A5A5;
    #1;
    total++;
    if (dmem_wen_o !== 1'b1 || dmem_adr_o !== 14'd5 || dmem_dat_o !== 32'h0000A5A5 || imem_wen_o !== 1'b0) begin
      bad++;
      $display("FAIL cpu_passthru dw=%b adr=%0d dat=%h iw=%b exp 1 5 0000a5a5 0",
               dmem_wen_o, dmem_adr_o, dmem_dat_o, imem_wen_o);
    end
    @(negedge clk);
    cpu_wen_i = 1'b0;
  endtask

  task automatic test_prog_basic;
    test_start("prog_basic");
    @(negedge clk);
    upg_wen_i = 1'b1; upg_adr_i = 15'h0003; upg_dat_i = 32'h11112222;
    #1;
    total++;
    if (imem_wen_o !== 1'b1 || imem_adr_o !== 14'd3 || imem_dat_o !== 32'h11112222 || dmem_wen_o !== 1'b0) begin
      bad++;
      $display("FAIL imem_route iw=%b adr=%0d dat=%h dw=%b exp 1 3 11112222 0",
               imem_wen_o, imem_adr_o, imem_dat_o, dmem_wen_o);
    end
    @(negedge clk);
    upg_adr_i = 15'h4007; upg_dat_i = 32'h33334444;
    #1;
    total++;
    if (dmem_wen_o !== 1'b1 || dmem_adr_o !== 14'd7 || dmem_dat_o !== 32'h33334444 || imem_wen_o !== 1'b0) begin
      bad++;
      $display("FAIL dmem_route dw=%b adr=%0d dat=%h iw=%b exp 1 7 33334444 0",
               dmem_wen_o, dmem_adr_o, dmem_dat_o, imem_wen_o);
    end
    @(negedge clk);
    upg_wen_i = 1'b0;
    total++;
    if (word_cnt_o !== 16'd2 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL prog_count cnt=%0d err=%b exp 2 0", word_cnt_o, err_o);
    end
  endtask

  // Still in PROG from the previous task.
  task automatic test_cpu_err;
    @(negedge clk);
    cpu_wen_i = 1'b1; cpu_adr_i = 14'd9; cpu_dat_i = 32'hDEADBEEF;
    #1;
    total++;
    if (dmem_wen_o !== 1'b0) begin
      bad++;
      $display("FAIL cpu_blocked dw=%b exp 0", dmem_wen_o);
    end
    @(negedge clk);
    cpu_wen_i = 1'b0;
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_set err=%b exp 1", err_o);
    end
    upg_done_i = 1'b1;
    @(negedge clk);
    upg_done_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL done_hold busy=%b cpu_rst=%b upg_rst=%b exp 0 1 1", busy_o, cpu_rst_o, upg_rst_o);
    end
    test_hold_len("err_hold");
    total++;
    if (err_o !== 1'b1 || word_cnt_o !== 16'd2) begin
      bad++;
      $display("FAIL err_sticky err=%b cnt=%0d exp 1 2", err_o, word_cnt_o);
    end
    test_start("err_clear");
    total++;
    if (err_o !== 1'b0 || word_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL start_clears err=%b cnt=%0d exp 0 0", err_o, word_cnt_o);
    end
  endtask

  // Still in PROG from the previous task.
  task automatic test_wen_and_done;
    @(negedge clk);
    upg_wen_i = 1'b1; upg_done_i = 1'b1; upg_adr_i = 15'h4001; upg_dat_i = 32'h55AA55AA;
    #1;
    total++;
    if (dmem_wen_o !== 1'b1 || dmem_adr_o !== 14'd1) begin
      bad++;
      $display("FAIL wen_done_write dw=%b adr=%0d exp 1 1", dmem_wen_o, dmem_adr_o);
    end
    @(negedge clk);
    upg_wen_i = 1'b0; upg_done_i = 1'b0;
    total++;
    if (word_cnt_o !== 16'd1 || busy_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL wen_done_state cnt=%0d busy=%b cpu_rst=%b exp 1 0 1", word_cnt_o, busy_o, cpu_rst_o);
    end
    test_hold_len("wen_done_hold");
    // Loader strobes outside PROG are ignored.
    @(negedge clk);
    upg_wen_i = 1'b1; upg_adr_i = 15'h0002;
    #1;
    total++;
    if (imem_wen_o !== 1'b0) begin
      bad++;
      $display("FAIL run_upg_ignored iw=%b exp 0", imem_wen_o);
    end
    @(negedge clk);
    upg_wen_i = 1'b0;
    total++;
    if (word_cnt_o !== 16'd1) begin
      bad++;
      $display("FAIL run_upg_uncounted cnt=%0d exp 1", word_cnt_o);
    end
  endtask

  task automatic test_reset_mid;
    test_start("mid_reset");
    loader_write(15'h0010, 32'h1);
    loader_write(15'h4011, 32'h2);
    loader_write(15'h0012, 32'h3);
    total++;
    if (word_cnt_o !== 16'd3) begin
      bad++;
      $display("FAIL mid_count cnt=%0d exp 3", word_cnt_o);
    end
    rst = 1'b1;
    #1;
    total++;
    if (upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b1 || word_cnt_o !== 16'd0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_vals upg_rst=%b cpu_rst=%b cnt=%0d busy=%b exp 1 1 0 0",
               upg_rst_o, cpu_rst_o, word_cnt_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    test_hold_len("mid_reset_hold");
  endtask

  task automatic test_saturation;
    test_start("sat");
    @(negedge clk);
    upg_wen_i = 1'b1; upg_adr_i = 15'h0000; upg_dat_i = 32'h0;
    repeat (65534) @(negedge clk);
    total++;
    if (word_cnt_o !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_near cnt=%h exp fffe", word_cnt_o);
    end
    repeat (3) @(negedge clk);
    upg_wen_i = 1'b0;
    total++;
    if (word_cnt_o !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_hold cnt=%h exp ffff", word_cnt_o);
    end
    upg_done_i = 1'b1;
    @(negedge clk);
    upg_done_i = 1'b0;
    // Start pulse entirely inside HOLD must be ignored.
    start_pg = 1'b1;
    repeat (4) @(negedge clk);
    start_pg = 1'b0;
    begin
      int n = 0;
      while (cpu_rst_o && n < 100) begin
        @(posedge clk); #1; n++;
      end
      total++;
      if (cpu_rst_o !== 1'b0) begin
        bad++;
        $display("FAIL sat_run timeout cpu_rst=%b exp 0", cpu_rst_o);
      end
    end
    repeat (6) @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || upg_rst_o !== 1'b1 || word_cnt_o !== 16'hFFFF) begin
      bad++;
      $display("FAIL hold_start_ignored busy=%b upg_rst=%b cnt=%h exp 0 1 ffff", busy_o, upg_rst_o, word_cnt_o);
    end
  endtask

  initial begin
    start_pg = 1'b0; upg_wen_i = 1'b0; upg_adr_i = '0; upg_dat_i = '0; upg_done_i = 1'b0;
    cpu_wen_i = 1'b0; cpu_adr_i = '0; cpu_dat_i = '0;
    test_reset;
    test_prog_basic;
    test_cpu_err;
    test_wen_and_done;
    test_reset_mid;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
